mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 22 ++
 rtl/mem_access_unit_mm_wb.sv | 40 ++++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: bus widths, register-index width,
// access FSM encoding and the word-alignment mask.
package mem_access_unit_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;

   // Low address bits that must be zero for a word access
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mau_state_e;

   function automatic logic word_aligned(input logic [1:0] addr_lsbs);
      return (addr_lsbs & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_unit_mm_wb.sv
// MEM/WB pipeline register. A stalled cycle inserts a bubble by clearing
// the write enable while data and destination hold their last values.
module mm_wb
   import mem_access_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [REG_W-1:0]  regdst_i,
   input  logic              regwrite_i,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [REG_W-1:0]  wb_regdst_o,
   output logic              wb_regwrite_o
);

   logic [DATA_W-1:0] data_q;
   logic [REG_W-1:0]  regdst_q;
   logic              regwrite_q;

   // Capture on advancing edges, bubble the write enable on stalled edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q     <= '0;
         regdst_q   <= '0;
         regwrite_q <= 1'b0;
      end else if (stall_i) begin
         regwrite_q <= 1'b0;
      end else begin
         data_q     <= data_i;
         regdst_q   <= regdst_i;
         regwrite_q <= regwrite_i;
      end
   end

   assign wb_data_o     = data_q;
   assign wb_regdst_o   = regdst_q;
   assign wb_regwrite_o = regwrite_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: sequences one data-memory access per instruction through a
// request/grant/rvalid handshake, stalls upstream while it is in flight,
// flags illegal accesses and feeds the MEM/WB register.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] mm_pc,
   input  logic [DATA_W-1:0] mm_result,
   input  logic [DATA_W-1:0] mm_mmdata,
   input  logic [REG_W-1:0]  mm_regdst,
   input  logic              mm_zero,
   input  logic              mm_memtoreg,
   input  logic              mm_regwrite,
   input  logic              mm_memread,
   input  logic              mm_memwrite,
   input  logic              mm_branch,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              mem_stall,
   output logic              pcsrc,
   output logic [DATA_W-1:0] branch_target,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  wb_regdst,
   output logic              wb_regwrite,
   output logic              mem_err
);

   mau_state_e        state_q, state_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic              err_q, err_d;
   logic              stall_raw;

   logic is_mem, is_access, is_bad;

   assign is_mem    = mm_memread | mm_memwrite;
   assign is_access = (mm_memread ^ mm_memwrite) & word_aligned(mm_result[1:0]);
   assign is_bad    = is_mem & ~is_access;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (is_access)   state_d = ST_REQ;
         ST_REQ:  if (dmem_gnt)    state_d = mm_memwrite ? ST_DONE : ST_WAIT;
         ST_WAIT: if (dmem_rvalid) state_d = ST_DONE;
         ST_DONE:                  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: request fields only in REQ, stall everywhere but DONE
   always_comb begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      stall_raw  = 1'b0;
      unique case (state_q)
         ST_IDLE: stall_raw = is_access;
         ST_REQ: begin
            dmem_req   = 1'b1;
            dmem_we    = mm_memwrite;
            dmem_addr  = mm_result;
            dmem_wdata = mm_mmdata;
            stall_raw  = 1'b1;
         end
         ST_WAIT: stall_raw = 1'b1;
         ST_DONE: stall_raw = 1'b0;
         default: stall_raw = 1'b0;
      endcase
   end

   // Stall and branch decision are forced low while reset is asserted
   assign mem_stall     = stall_raw & ~rst;
   assign pcsrc         = mm_branch & mm_zero & ~mem_stall & ~rst;
   assign branch_target = mm_pc;

   // Load data capture and sticky error detection
   always_comb begin
      load_d = load_q;
      err_d  = err_q;
      if (state_q == ST_WAIT && dmem_rvalid) load_d = dmem_rdata;
      if (state_q == ST_IDLE && is_bad)      err_d  = 1'b1;
   end

   // Load register and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_q <= '0;
         err_q  <= 1'b0;
      end else begin
         load_q <= load_d;
         err_q  <= err_d;
      end
   end

   assign mem_err = err_q;

   mm_wb u_mm_wb (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (mem_stall),
      .data_i        (mm_memtoreg ? load_q : mm_result),
      .regdst_i      (mm_regdst),
      .regwrite_i    (mm_regwrite & ~is_bad),
      .wb_data_o     (wb_data),
      .wb_regdst_o   (wb_regdst),
      .wb_regwrite_o (wb_regwrite)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios followed by randomized
// instructions, checked against a cycle-count/result model of the MEM stage.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mm_pc, mm_result, mm_mmdata;
   logic [4:0]  mm_regdst;
   logic        mm_zero, mm_memtoreg, mm_regwrite, mm_memread, mm_memwrite, mm_branch;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        mem_stall, pcsrc;
   logic [31:0] branch_target, wb_data;
   logic [4:0]  wb_regdst;
   logic        wb_regwrite, mem_err;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Reference state: last loaded word and sticky error
   logic [31:0] m_load;
   logic        m_err;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .mm_pc(mm_pc), .mm_result(mm_result), .mm_mmdata(mm_mmdata), .mm_regdst(mm_regdst),
      .mm_zero(mm_zero), .mm_memtoreg(mm_memtoreg), .mm_regwrite(mm_regwrite),
      .mm_memread(mm_memread), .mm_memwrite(mm_memwrite), .mm_branch(mm_branch),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .pcsrc(pcsrc), .branch_target(branch_target),
      .wb_data(wb_data), .wb_regdst(wb_regdst), .wb_regwrite(wb_regwrite), .mem_err(mem_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      mm_pc = '0; mm_result = '0; mm_mmdata = '0; mm_regdst = '0;
      mm_zero = 0; mm_memtoreg = 0; mm_regwrite = 0; mm_memread = 0; mm_memwrite = 0; mm_branch = 0;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
   endtask

   // Present one instruction (called at posedge+1) and act as the memory.
   // gd = REQ cycles without grant before the granting one; rd = WAIT cycles
   // before rvalid. junk drives stray rvalid outside WAIT.
   task automatic run_instr(input string tag, input logic [31:0] pc, input logic [31:0] result,
                            input logic [31:0] mdata, input logic [4:0] regdst, input bit zero,
                            input bit memtoreg, input bit regwrite, input bit memread,
                            input bit memwrite, input bit branch, input int unsigned gd,
                            input int unsigned rd, input logic [31:0] rdata, input bit junk);
      bit acc, bad, ld, granted, req_ok, bubble_ok, pc_ok, done, stall_now;
      int unsigned exp_stall, exp_req, stalls, reqs, waits, cyc;
      logic [31:0] exp_data;
      logic [1:0]  lsbs;
      lsbs = result[1:0];
      acc = (memread ^ memwrite) && (lsbs == 2'b00);
      bad = (memread || memwrite) && !acc;
      ld  = acc && memread;
      exp_stall = !acc ? 0 : (ld ? gd + rd + 3 : gd + 2);
      exp_req   = acc ? gd + 1 : 0;
      stalls = 0; reqs = 0; waits = 0; cyc = 0;
      granted = 0; req_ok = 1; bubble_ok = 1; pc_ok = 1; done = 0;

      mm_pc = pc; mm_result = result; mm_mmdata = mdata; mm_regdst = regdst;
      mm_zero = zero; mm_memtoreg = memtoreg; mm_regwrite = regwrite;
      mm_memread = memread; mm_memwrite = memwrite; mm_branch = branch;
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;

      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         stall_now = mem_stall;
         if (pcsrc !== (branch & zero & (cyc > exp_stall))) pc_ok = 0;
         if (branch_target !== pc) pc_ok = 0;
         if (stall_now) stalls++;
         if (dmem_req) begin
            reqs++;
            if (dmem_we !== memwrite || dmem_addr !== result || dmem_wdata !== mdata) req_ok = 0;
            if (reqs == gd + 1) begin dmem_gnt = 1; granted = 1; end
            if (junk) begin dmem_rvalid = 1; dmem_rdata = $urandom; end
         end else if (granted && stall_now && ld) begin
            waits++;
            if (waits == rd + 1) begin dmem_rvalid = 1; dmem_rdata = rdata; end
         end else if (junk) begin
            dmem_rvalid = 1; dmem_rdata = $urandom;
         end
         @(posedge clk); #1;
         dmem_gnt = 0; dmem_rvalid = 0;
         if (stall_now) begin
            if (wb_regwrite !== 1'b0) bubble_ok = 0;
         end else begin
            done = 1;
         end
      end

      if (ld)  m_load = rdata;
      if (bad) m_err  = 1'b1;
      exp_data = memtoreg ? m_load : result;

      check({tag, ".done"},      32'(done),      32'd1);
      check({tag, ".stalls"},    stalls,         exp_stall);
      check({tag, ".reqs"},      reqs,           exp_req);
      check({tag, ".req_fld"},   32'(req_ok),    32'd1);
      check({tag, ".bubble"},    32'(bubble_ok), 32'd1);
      check({tag, ".pcsrc"},     32'(pc_ok),     32'd1);
      check({tag, ".wb_data"},   wb_data,        exp_data);
      check({tag, ".wb_regdst"}, 32'(wb_regdst), 32'(regdst));
      check({tag, ".wb_rw"},     32'(wb_regwrite), 32'(regwrite & !bad));
      check({tag, ".mem_err"},   32'(mem_err),   32'(m_err));
   endtask

   task automatic run_random(input string tag);
      int unsigned k;
      logic [31:0] addr;
      bit rdb, wrb;
      k = $urandom_range(0, 9);
      addr = $urandom & 32'hFFFF_FFFC;
      rdb = 0; wrb = 0;
      if (k >= 3 && k <= 5) rdb = 1;
      else if (k == 6 || k == 7) wrb = 1;
      else if (k == 8) begin
         if ($urandom_range(0, 1) == 1) rdb = 1; else wrb = 1;
         addr = addr | 32'($urandom_range(1, 3));
      end else if (k == 9) begin
         rdb = 1; wrb = 1;
      end
      run_instr(tag, $urandom, addr, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), rdb, wrb, 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom, 1'($urandom));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_load = '0;
      m_err  = 1'b0;
      clear_inputs();
      rst = 1'b1;
      #12;
      check("rst.req",    32'(dmem_req),    32'd0);
      check("rst.stall",  32'(mem_stall),   32'd0);
      check("rst.wb_rw",  32'(wb_regwrite), 32'd0);
      check("rst.wb_dat", wb_data,          32'd0);
      check("rst.err",    32'(mem_err),     32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      run_instr("alu",    32'h0,  32'h55,  32'h0,    5'd7, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
      run_instr("load",   32'h0,  32'h100, 32'h0,    5'd3, 0, 1, 1, 1, 0, 0, 0, 2, 32'hDEADBEEF, 0);
      run_instr("store",  32'h0,  32'h200, 32'h1234, 5'd4, 0, 0, 0, 0, 1, 0, 2, 0, 32'h0, 0);
      run_instr("br_tk",  32'h40, 32'h0,   32'h0,    5'd0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
      run_instr("br_nt",  32'h40, 32'h0,   32'h0,    5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
      run_instr("misal",  32'h0,  32'h102, 32'h0,    5'd5, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0, 0);
      run_instr("alu2",   32'h0,  32'h77,  32'h0,    5'd6, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);

      for (int i = 0; i < 30; i++) run_random($sformatf("rnd%0d", i));

      // Reset while a load waits for its data
      mm_result = 32'h300; mm_memread = 1; mm_memwrite = 0; mm_memtoreg = 1;
      mm_regwrite = 1; mm_regdst = 5'd9;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("rw.req", 32'(dmem_req), 32'd1);
      dmem_gnt = 1;
      @(posedge clk); #1;
      dmem_gnt = 0;
      @(negedge clk);
      check("rw.wait_stall", 32'(mem_stall), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rw.rst_req",   32'(dmem_req),    32'd0);
      check("rw.rst_we",    32'(dmem_we),     32'd0);
      check("rw.rst_stall", 32'(mem_stall),   32'd0);
      check("rw.rst_pcsrc", 32'(pcsrc),       32'd0);
      check("rw.rst_wbrw",  32'(wb_regwrite), 32'd0);
      check("rw.rst_wbdat", wb_data,          32'd0);
      check("rw.rst_wbdst", 32'(wb_regdst),   32'd0);
      check("rw.rst_err",   32'(mem_err),     32'd0);
      clear_inputs();
      m_load = '0;
      m_err  = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      check("stray.req",   32'(dmem_req),  32'd0);
      check("stray.stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem_gnt = 0; dmem_rvalid = 0;
      check("stray.wbrw",  32'(wb_regwrite), 32'd0);
      check("stray.wbdat", wb_data,          32'd0);
      run_instr("post_rst", 32'h0, 32'h99, 32'h0, 5'd2, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 1);

      for (int i = 0; i < 20; i++) run_random($sformatf("rnd_b%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
